// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO word offsets,
// TIMER_CTRL bit positions and the LED register width.
package dmem_mmio_pkg;

    localparam logic [2:0] OFF_BTN_EDGE  = 3'd0;
    localparam logic [2:0] OFF_BTN_RAW   = 3'd1;
    localparam logic [2:0] OFF_TIMER_CNT = 3'd2;
    localparam logic [2:0] OFF_TIMER_CMP = 3'd3;
    localparam logic [2:0] OFF_TIMER_CTL = 3'd4;
    localparam logic [2:0] OFF_LED       = 3'd5;

    localparam int unsigned MMIO_WORDS = 8;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_FLAG_BIT   = 2;

    localparam int unsigned LED_W = 16;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a vector of raw buttons, plus a one-cycle
// rising-edge pulse against the previous synchronized level.
module btn_sync_edge #(
    parameter int unsigned NBTN = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] level_o,
    output logic [NBTN-1:0] rise_o
);

    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an 8-word MMIO page (button edges,
// prescaled timer with compare flag, LED register). Reads are side-effect free.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int unsigned NBTN      = 4,
    parameter int unsigned TICK_DIV  = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q_dmem,
    input  logic [NBTN-1:0]  btn_in,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq,
    output logic             addr_fault
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    // Address decode
    logic        ram_hit;
    logic        mmio_hit;
    logic [31:0] mmio_off_full;
    logic [2:0]  mmio_off;
    logic [AW-1:0] ram_idx;

    assign mmio_off_full = address_dmem - MMIO_BASE;
    assign ram_hit       = address_dmem < DEPTH_W;
    assign mmio_hit      = (address_dmem >= MMIO_BASE) && (mmio_off_full < 32'(MMIO_WORDS));
    assign mmio_off      = mmio_off_full[2:0];
    assign ram_idx       = address_dmem[AW-1:0];

    logic wr_ram;
    logic wr_mmio;
    logic wr_edge;
    logic wr_cnt;
    logic wr_cmp;
    logic wr_ctl;
    logic wr_led;
    logic wr_unmapped;

    assign wr_ram      = wren && ram_hit;
    assign wr_mmio     = wren && mmio_hit;
    assign wr_edge     = wr_mmio && (mmio_off == OFF_BTN_EDGE);
    assign wr_cnt      = wr_mmio && (mmio_off == OFF_TIMER_CNT);
    assign wr_cmp      = wr_mmio && (mmio_off == OFF_TIMER_CMP);
    assign wr_ctl      = wr_mmio && (mmio_off == OFF_TIMER_CTL);
    assign wr_led      = wr_mmio && (mmio_off == OFF_LED);
    assign wr_unmapped = wren && !ram_hit && !mmio_hit;

    // Data RAM (contents intentionally not reset)
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_ram) begin
            mem[ram_idx] <= data;
        end
    end

    // Buttons
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_rise;

    btn_sync_edge #(
        .NBTN (NBTN)
    ) u_btn (
        .clk_i   (clock),
        .rst_ni  (reset),
        .btn_i   (btn_in),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    // State registers
    logic [NBTN-1:0]  edge_q, edge_d;
    logic [31:0]      presc_q, presc_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      cmp_q, cmp_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             flag_q, flag_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             fault_q, fault_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        tick;
    logic [31:0] cnt_inc;
    logic        flag_set;
    logic        flag_clr;

    // Set beats a same-cycle write-1-to-clear for both edge bits and the flag.
    always_comb begin
        edge_d = (edge_q & ~(wr_edge ? data[NBTN-1:0] : '0)) | btn_rise;

        tick     = en_q && (presc_q == TICK_LAST);
        cnt_inc  = cnt_q + 32'd1;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        if (en_q) begin
            presc_d = tick ? '0 : presc_q + 32'd1;
            if (tick) begin
                cnt_d = cnt_inc;
            end
        end
        // A CNT write overrides a coincident increment.
        if (wr_cnt) begin
            cnt_d   = '0;
            presc_d = '0;
        end

        flag_set = tick && !wr_cnt && (cnt_inc == cmp_q);
        flag_clr = wr_ctl && data[CTRL_FLAG_BIT];
        flag_d   = (flag_q && !flag_clr) || flag_set;

        cmp_d    = wr_cmp ? data : cmp_q;
        en_d     = wr_ctl ? data[CTRL_EN_BIT] : en_q;
        irq_en_d = wr_ctl ? data[CTRL_IRQ_EN_BIT] : irq_en_q;
        led_d    = wr_led ? data[LED_W-1:0] : led_q;
        fault_d  = fault_q || wr_unmapped;
    end

    // Read path: registered, write-first for RAM, zero for unmapped/reserved.
    logic [31:0] ctl_rd;

    always_comb begin
        ctl_rd                  = '0;
        ctl_rd[CTRL_EN_BIT]     = en_q;
        ctl_rd[CTRL_IRQ_EN_BIT] = irq_en_q;
        ctl_rd[CTRL_FLAG_BIT]   = flag_q;

        rdata_d = '0;
        if (ram_hit) begin
            rdata_d = wren ? data : mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_BTN_EDGE:  rdata_d = 32'(edge_q);
                OFF_BTN_RAW:   rdata_d = 32'(btn_level);
                OFF_TIMER_CNT: rdata_d = cnt_q;
                OFF_TIMER_CMP: rdata_d = cmp_q;
                OFF_TIMER_CTL: rdata_d = ctl_rd;
                OFF_LED:       rdata_d = 32'(led_q);
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_q   <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            cmp_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            flag_q   <= 1'b0;
            led_q    <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            edge_q   <= edge_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            flag_q   <= flag_d;
            led_q    <= led_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    assign q_dmem     = rdata_q;
    assign led_out    = led_q;
    assign timer_irq  = flag_q && irq_en_q;
    assign addr_fault = fault_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench: reads push expected q_dmem into a queue; a monitor pops and
// compares one cycle later. Side outputs are checked directly.
module tb_dmem_mmio_responder;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned NBTN  = 4;
    localparam logic [31:0] B     = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [3:0]  btn_in;
    logic [15:0] led_out;
    logic        timer_irq;
    logic        addr_fault;

    dmem_mmio_responder #(
        .DEPTH     (DEPTH),
        .MMIO_BASE (B),
        .NBTN      (NBTN),
        .TICK_DIV  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .btn_in       (btn_in),
        .led_out      (led_out),
        .timer_irq    (timer_irq),
        .addr_fault   (addr_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        chk_issue = 1'b0;
    logic        chk_q = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    always @(posedge clock) chk_q <= chk_issue;

    always @(negedge clock) begin
        logic [31:0] e;
        string       nm;
        if (chk_q) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got %h with no expected entry", q_dmem);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (q_dmem !== e) begin
                    n_bad++;
                    $display("FAIL %s: q_dmem got %h expected %h", nm, q_dmem, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive just after a falling edge, return at the next one.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic chk, input logic [31:0] exp, input string nm);
        address_dmem = a;
        data         = d;
        wren         = we;
        chk_issue    = chk;
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(negedge clock);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(a, d, 1'b1, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        cyc(a, 32'h0, 1'b0, 1'b1, exp, nm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(address_dmem, 32'h0, 1'b0, 1'b0, 32'h0, "");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        btn_in       = '0;
        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_q_dmem", q_dmem, 32'h0);
        check("reset_led", 32'(led_out), 32'h0);
        check("reset_irq", 32'(timer_irq), 32'h0);
        check("reset_fault", 32'(addr_fault), 32'h0);
        reset = 1'b1;

        // RAM write then read; write-first same-cycle access
        wr(32'd10, 32'hDEADBEEF);
        rd(32'd10, 32'hDEADBEEF, "ram_rd10");
        cyc(32'd11, 32'd5, 1'b1, 1'b1, 32'd5, "ram_write_first");
        rd(32'd11, 32'd5, "ram_rd11");

        // Button edge capture on btn_in[2]
        btn_in = 4'b0100;
        idle(3);
        rd(B + 0, 32'd4, "btn_edge_set");
        rd(B + 1, 32'd4, "btn_raw_high");
        btn_in = 4'b0000;
        idle(3);
        rd(B + 0, 32'd4, "btn_edge_sticky");
        rd(B + 0, 32'd4, "btn_edge_reread");
        rd(B + 1, 32'd0, "btn_raw_low");
        wr(B + 1, 32'hF);
        wr(B + 0, 32'd4);
        rd(B + 0, 32'd0, "btn_edge_w1c");
        // Rise pulse lands on the same edge as the clearing write
        btn_in = 4'b0100;
        idle(2);
        wr(B + 0, 32'd4);
        rd(B + 0, 32'd4, "btn_set_beats_w1c");
        btn_in = 4'b0000;

        // Timer: TICK_DIV=4, CMP=3
        wr(B + 3, 32'd3);
        rd(B + 3, 32'd3, "timer_cmp_rd");
        wr(B + 4, 32'd3);
        idle(12);
        rd(B + 2, 32'd3, "timer_cnt_12cyc");
        check("timer_irq_set", 32'(timer_irq), 32'h1);
        rd(B + 4, 32'd7, "timer_ctl_flag");
        wr(B + 4, 32'd7);
        check("timer_irq_clr", 32'(timer_irq), 32'h0);
        rd(B + 4, 32'd3, "timer_ctl_after_clr");
        rd(B + 2, 32'd4, "timer_keeps_counting");
        idle(2);
        wr(B + 2, 32'h1234);
        rd(B + 2, 32'd0, "timer_cnt_write_beats_tick");
        wr(B + 4, 32'd0);

        // Wrap: park the count at all-ones while disabled, then let it tick
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        rd(B + 2, 32'hFFFF_FFFF, "timer_cnt_held");
        wr(B + 4, 32'd1);
        idle(3);
        rd(B + 2, 32'd0, "timer_wrap_zero");

        // LED, reserved, unmapped
        wr(B + 5, 32'h0001_ABCD);
        check("led_out", 32'(led_out), 32'h0000_ABCD);
        rd(B + 5, 32'h0000_ABCD, "led_rd");
        wr(32'd0, 32'h1234_5678);
        wr(B + 6, 32'h1);
        check("reserved_no_fault", 32'(addr_fault), 32'h0);
        rd(B + 6, 32'h0, "reserved_rd");
        wr(DEPTH, 32'hCAFE_F00D);
        check("fault_set", 32'(addr_fault), 32'h1);
        rd(32'd0, 32'h1234_5678, "ram_untouched");
        rd(DEPTH, 32'h0, "unmapped_rd");
        wr(B + 8, 32'h1);
        check("fault_sticky", 32'(addr_fault), 32'h1);

        // Async reset mid timer run
        rd(B + 5, 32'h0000_ABCD, "led_rd_pre_reset");
        idle(1);
        #2 reset = 1'b0;
        #1;
        check("areset_q_dmem", q_dmem, 32'h0);
        check("areset_led", 32'(led_out), 32'h0);
        check("areset_irq", 32'(timer_irq), 32'h0);
        check("areset_fault", 32'(addr_fault), 32'h0);
        @(negedge clock);
        check("reset_hold_q_dmem", q_dmem, 32'h0);
        reset = 1'b1;
        rd(B + 2, 32'h0, "cnt_after_reset");
        rd(B + 4, 32'h0, "ctl_after_reset");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
